// File: rtl/multi_lane_frame_aligner.sv
// Per-lane comma framing, payload extraction and FIFO buffering,
// with a read FSM that streams lane-aligned payload words.
module multi_lane_frame_aligner #(
  parameter int LANES       = 2,
  parameter int DATA_W      = 16,
  parameter int K_W         = 2,
  parameter logic [K_W-1:0] COMMA_K = 2'b01,
  parameter int FRAME_LEN   = 20,
  parameter int PAY_START   = 3,
  parameter int PAY_LEN     = 16,
  parameter int DEPTH       = 64,
  parameter int START_LEVEL = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [LANES*DATA_W-1:0]              data_in,
  input  logic [LANES*K_W-1:0]                 charisk_in,
  output logic [LANES*DATA_W-1:0]              out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  input  logic                                 flush,
  input  logic                                 clr_err,
  output logic [LANES*$clog2(DEPTH+1)-1:0]     level,
  output logic [LANES-1:0]                     overflow,
  output logic [LANES-1:0]                     frame_err,
  output logic                                 underrun,
  output logic [1:0]                           state
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FRAME_LEN);

  localparam logic [PW-1:0] POS_LAST = PW'(FRAME_LEN-1);
  localparam logic [PW-1:0] POS_P0   = PW'(PAY_START);
  localparam logic [PW-1:0] POS_P1   = PW'(PAY_START+PAY_LEN-1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_GO   = LW'(START_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   und_q, und_d;

  logic [PW-1:0]     pos_q     [LANES];
  logic [PW-1:0]     pos_d     [LANES];
  logic              wr_en_q   [LANES];
  logic              wr_en_d   [LANES];
  logic [DATA_W-1:0] wr_data_q [LANES];
  logic [DATA_W-1:0] wr_data_d [LANES];
  logic [AW-1:0]     wptr_q    [LANES];
  logic [AW-1:0]     wptr_d    [LANES];
  logic [AW-1:0]     rptr_q    [LANES];
  logic [AW-1:0]     rptr_d    [LANES];
  logic [LW-1:0]     lvl_q     [LANES];
  logic [LW-1:0]     lvl_d     [LANES];
  logic [LANES-1:0]  ovf_q, ovf_d;
  logic [LANES-1:0]  ferr_q, ferr_d;
  logic [LANES-1:0]  push;
  logic [DATA_W-1:0] mem_q     [LANES][DEPTH];

  logic all_ne, all_ge, any_e_n, any_ne_n, pop;

  // Frame tracking: pos is the index of the word presented this cycle
  always_comb begin
    logic is_comma;
    for (int i = 0; i < LANES; i++) begin
      is_comma     = charisk_in[i*K_W +: K_W] == COMMA_K;
      pos_d[i]     = pos_q[i];
      wr_en_d[i]   = 1'b0;
      wr_data_d[i] = data_in[i*DATA_W +: DATA_W];
      ferr_d[i]    = ferr_q[i] && !clr_err;
      if (is_comma) begin
        pos_d[i] = PW'(1);
        if (pos_q[i] != '0 && !flush) ferr_d[i] = 1'b1;
      end else if (pos_q[i] != '0) begin
        pos_d[i]   = (pos_q[i] == POS_LAST) ? '0 : pos_q[i] + PW'(1);
        wr_en_d[i] = (pos_q[i] >= POS_P0) && (pos_q[i] <= POS_P1);
      end
      if (flush) begin
        pos_d[i]   = '0;
        wr_en_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    all_ne = 1'b1;
    all_ge = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      all_ne = all_ne && (lvl_q[i] != '0);
      all_ge = all_ge && (lvl_q[i] >= LVL_GO);
    end
  end

  assign out_valid = (state_q == S_RUN) && all_ne;
  assign pop       = out_valid && out_ready;

  // A pop frees the slot the same cycle, so a write to a full lane still lands
  always_comb begin
    logic full;
    any_e_n  = 1'b0;
    any_ne_n = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      full      = lvl_q[i] == LVL_FULL;
      push[i]   = wr_en_q[i] && (!full || pop) && !flush;
      ovf_d[i]  = (ovf_q[i] && !clr_err) ||
                  (wr_en_q[i] && full && !pop && !flush);
      lvl_d[i]  = lvl_q[i] + LW'(push[i]) - LW'(pop);
      wptr_d[i] = push[i] ? wptr_q[i] + AW'(1) : wptr_q[i];
      rptr_d[i] = pop ? rptr_q[i] + AW'(1) : rptr_q[i];
      if (flush) begin
        lvl_d[i]  = '0;
        wptr_d[i] = '0;
        rptr_d[i] = '0;
      end
      any_e_n  = any_e_n || (lvl_d[i] == '0);
      any_ne_n = any_ne_n || (lvl_d[i] != '0);
    end
  end

  always_comb begin
    state_d = state_q;
    und_d   = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FILL;
      S_FILL: if (all_ge) state_d = S_RUN;
      S_RUN: begin
        if (any_e_n && any_ne_n) begin
          state_d = S_FILL;
          und_d   = 1'b1;
        end
      end
      default: state_d = S_FILL;
    endcase
    if (flush) begin
      state_d = S_FILL;
      und_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      und_q   <= 1'b0;
      ovf_q   <= '0;
      ferr_q  <= '0;
      for (int i = 0; i < LANES; i++) begin
        pos_q[i]     <= '0;
        wr_en_q[i]   <= 1'b0;
        wr_data_q[i] <= '0;
        wptr_q[i]    <= '0;
        rptr_q[i]    <= '0;
        lvl_q[i]     <= '0;
      end
    end else begin
      state_q <= state_d;
      und_q   <= und_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
      for (int i = 0; i < LANES; i++) begin
        pos_q[i]     <= pos_d[i];
        wr_en_q[i]   <= wr_en_d[i];
        wr_data_q[i] <= wr_data_d[i];
        wptr_q[i]    <= wptr_d[i];
        rptr_q[i]    <= rptr_d[i];
        lvl_q[i]     <= lvl_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= wr_data_q[i];
    end
  end

  always_comb begin
    out_data = '0;
    level    = '0;
    for (int i = 0; i < LANES; i++) begin
      out_data[i*DATA_W +: DATA_W] = out_valid ? mem_q[i][rptr_q[i]] : '0;
      level[i*LW +: LW]            = lvl_q[i];
    end
  end

  assign overflow  = ovf_q;
  assign frame_err = ferr_q;
  assign underrun  = und_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multi_lane_frame_aligner.sv
// Randomised scoreboard bench for multi_lane_frame_aligner:
// queue-based lane model, monitor compares every cycle.
module tb_multi_lane_frame_aligner;

  localparam int LANES = 2;
  localparam int DW    = 16;
  localparam int KW    = 2;
  localparam int FL    = 20;
  localparam int PS    = 3;
  localparam int PL    = 16;
  localparam int DEPTH = 64;
  localparam int SL    = 32;
  localparam int LW    = 7;
  localparam logic [1:0] COMMA = 2'b01;

  logic clk = 1'b0;
  logic rst;
  logic [LANES*DW-1:0] data_in;
  logic [LANES*KW-1:0] charisk_in;
  logic [LANES*DW-1:0] out_data;
  logic out_valid, out_ready, flush, clr_err;
  logic [LANES*LW-1:0] level;
  logic [LANES-1:0] overflow, frame_err;
  logic underrun;
  logic [1:0] state;

  always #5 clk = ~clk;

  multi_lane_frame_aligner #(
    .LANES(LANES), .DATA_W(DW), .K_W(KW), .COMMA_K(COMMA),
    .FRAME_LEN(FL), .PAY_START(PS), .PAY_LEN(PL),
    .DEPTH(DEPTH), .START_LEVEL(SL)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .charisk_in(charisk_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .clr_err(clr_err), .level(level),
    .overflow(overflow), .frame_err(frame_err),
    .underrun(underrun), .state(state)
  );

  int checks = 0;
  int errors = 0;

  // reference model: per-lane payload queues
  logic [15:0] mq0[$];
  logic [15:0] mq1[$];
  int          m_idx  [LANES];
  bit          m_pend [LANES];
  logic [15:0] m_pdat [LANES];
  int          m_mode;
  logic [1:0]  m_ovf, m_ferr;
  bit          m_und;

  int gk  [LANES];
  bit gon [LANES];
  bit seqd, rnd_mode, mon_en;

  function automatic int msize(input int l);
    return (l == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [15:0] mfront(input int l);
    return (l == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic mpop(input int l);
    if (l == 0) void'(mq0.pop_front());
    else void'(mq1.pop_front());
  endtask

  task automatic mpush(input int l, input logic [15:0] w);
    if (l == 0) mq0.push_back(w);
    else mq1.push_back(w);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    for (int l = 0; l < LANES; l++) begin
      m_idx[l]  = 0;
      m_pend[l] = 1'b0;
      m_pdat[l] = '0;
    end
    m_mode = 0;
    m_ovf  = '0;
    m_ferr = '0;
    m_und  = 1'b0;
  endtask

  // Applies one clock edge worth of the block's rules to the model
  task automatic model_step();
    bit pop, fill_ok, any_e, any_ne;
    logic [1:0] k;
    if (flush) begin
      mq0.delete();
      mq1.delete();
      for (int l = 0; l < LANES; l++) begin
        m_idx[l]  = 0;
        m_pend[l] = 1'b0;
      end
      m_mode = 1;
      m_und  = 1'b0;
      if (clr_err) begin
        m_ovf  = '0;
        m_ferr = '0;
      end
      return;
    end
    fill_ok = (msize(0) >= SL) && (msize(1) >= SL);
    pop = (m_mode == 2) && msize(0) > 0 && msize(1) > 0 && out_ready;
    if (clr_err) begin
      m_ovf  = '0;
      m_ferr = '0;
    end
    for (int l = 0; l < LANES; l++) begin
      if (pop) mpop(l);
      if (m_pend[l]) begin
        if (msize(l) < DEPTH) mpush(l, m_pdat[l]);
        else m_ovf[l] = 1'b1;
      end
      k = charisk_in[l*KW +: KW];
      m_pend[l] = 1'b0;
      m_pdat[l] = data_in[l*DW +: DW];
      if (k == COMMA) begin
        if (m_idx[l] != 0) m_ferr[l] = 1'b1;
        m_idx[l] = 1;
      end else if (m_idx[l] != 0) begin
        m_pend[l] = (m_idx[l] >= PS) && (m_idx[l] < PS + PL);
        m_idx[l]  = (m_idx[l] + 1) % FL;
      end
    end
    m_und = 1'b0;
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (fill_ok) m_mode = 2;
    end else begin
      any_e  = (msize(0) == 0) || (msize(1) == 0);
      any_ne = (msize(0) != 0) || (msize(1) != 0);
      if (any_e && any_ne) begin
        m_und  = 1'b1;
        m_mode = 1;
      end
    end
  endtask

  // monitor: compares DUT outputs against the model's expectations
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        ev = (m_mode == 2) && msize(0) > 0 && msize(1) > 0;
        chk("state", 32'(state), 32'(m_mode));
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("underrun", 32'(underrun), 32'(m_und));
        for (int l = 0; l < LANES; l++) begin
          chk($sformatf("level%0d", l), 32'(level[l*LW +: LW]), 32'(msize(l)));
          if (ev)
            chk($sformatf("out_data%0d", l), 32'(out_data[l*DW +: DW]),
                32'(mfront(l)));
        end
      end
    end
  end

  task automatic cyc(input bit rdy, input bit fl, input bit clr);
    logic [1:0]  k;
    logic [15:0] d;
    @(negedge clk);
    if (!rst) model_step();
    for (int l = 0; l < LANES; l++) begin
      if (gon[l] && !(rnd_mode && gk[l] == 0 && $urandom_range(3) == 0)) begin
        if (rnd_mode && gk[l] > 0 && $urandom_range(199) == 0) gk[l] = 0;
        if (gk[l] == 0) k = COMMA;
        else k = (rnd_mode && $urandom_range(7) == 0) ? 2'b10 : 2'b00;
        d = seqd ? 16'(gk[l]) : 16'($urandom);
        gk[l] = (gk[l] + 1) % FL;
      end else begin
        k = (rnd_mode && $urandom_range(7) == 0) ? 2'b10 : 2'b00;
        d = 16'($urandom);
      end
      charisk_in[l*KW +: KW] = k;
      data_in[l*DW +: DW]    = d;
    end
    out_ready = rdy;
    flush     = fl;
    clr_err   = clr;
  endtask

  task automatic gens(input bit on);
    for (int l = 0; l < LANES; l++) begin
      gon[l] = on;
      gk[l]  = 0;
    end
  endtask

  initial begin
    rst = 1'b1;
    data_in = '0;
    charisk_in = '0;
    out_ready = 1'b0;
    flush = 1'b0;
    clr_err = 1'b0;
    seqd = 1'b0;
    rnd_mode = 1'b0;
    mon_en = 1'b0;
    gens(1'b0);
    model_reset();
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_flags", 32'({overflow, frame_err, underrun}), 32'd0);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // aligned lanes, sequential data
    seqd = 1'b1;
    gens(1'b1);
    repeat (80) cyc(1, 0, 0);
    gens(1'b0);
    repeat (60) cyc(1, 0, 0);
    chk("p1_state_run", 32'(state), 32'd2);
    chk("p1_drained", 32'(level), 32'd0);
    seqd = 1'b0;

    // lane1 lags lane0 by 7 cycles, then lane1 stops
    cyc(1, 1, 0);
    gon[0] = 1'b1;
    gk[0] = 0;
    repeat (7) cyc(1, 0, 0);
    gon[1] = 1'b1;
    gk[1] = 0;
    repeat (160) cyc(1, 0, 0);
    gon[1] = 1'b0;
    repeat (60) cyc(1, 0, 0);
    gon[0] = 1'b0;
    repeat (30) cyc(1, 0, 0);

    // stall with continuous frames
    cyc(0, 1, 0);
    gens(1'b1);
    repeat (130) cyc(0, 0, 0);
    chk("p3_full0", 32'(level[0 +: LW]), 32'd64);
    chk("p3_ovf", 32'(overflow), 32'd3);
    cyc(0, 0, 1);
    repeat (5) cyc(1, 0, 0);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    chk("p3_ovf_clr", 32'(overflow), 32'd0);
    repeat (40) cyc(1, 0, 0);

    // early comma on lane0 at pos 9
    gens(1'b0);
    cyc(1, 1, 0);
    gens(1'b1);
    repeat (29) cyc(1, 0, 0);
    gk[0] = 0;
    repeat (60) cyc(1, 0, 0);
    chk("p4_ferr", 32'(frame_err), 32'd1);

    // random traffic
    rnd_mode = 1'b1;
    repeat (2500)
      cyc($urandom_range(3) != 0, $urandom_range(299) == 0,
          $urandom_range(49) == 0);

    // asynchronous reset mid-stream
    #3 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_flags", 32'({overflow, frame_err, underrun}), 32'd0);
    model_reset();
    repeat (2) cyc(1, 0, 0);
    rst = 1'b0;
    repeat (200)
      cyc($urandom_range(3) != 0, 1'b0, $urandom_range(49) == 0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
